ro_puf_seq_ctrl: RTL and testbench



---
 rtl/ro_puf_seq_ctrl_if.sv | 27 ++
 rtl/ro_puf_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ro_puf_seq_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ro_puf_seq_ctrl_if.sv
// Signal bundle between the RO-PUF sequencer and its neighbours (RO counter ctrl, shift register, signature RAM).
// master = sequencer side, slave = environment side.
interface ro_puf_seq_ctrl_if #(
   parameter int ADDR_W = 2,
   parameter int CHAL_W = 7
);
   logic              start;
   logic [1:0]        counter_ctrl_state;
   logic              roen;
   logic              shift_reg_en;
   logic              ram_wren;
   logic [ADDR_W-1:0] ram_addr;
   logic [CHAL_W-1:0] chal_idx;
   logic              busy;
   logic              done;
   logic              error;

   modport master (
      input  start, counter_ctrl_state,
      output roen, shift_reg_en, ram_wren, ram_addr, chal_idx, busy, done, error
   );

   modport slave (
      output start, counter_ctrl_state,
      input  roen, shift_reg_en, ram_wren, ram_addr, chal_idx, busy, done, error
   );
endinterface

// File: rtl/ro_puf_seq_ctrl.sv
// RO-PUF sequencer: one RO-pair comparison and shift pulse per signature bit, one RAM write per WORD_BITS bits.
// Optional measurement watchdog with sticky error flag is enabled by defining PUF_TIMEOUT_EN.
module ro_puf_seq_ctrl #(
   parameter int SIG_BITS       = 128,
   parameter int WORD_BITS      = 32,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic               clk,
   input logic               rst,
   ro_puf_seq_ctrl_if.master bus
);
   localparam int NUM_WORDS = SIG_BITS / WORD_BITS;
   localparam int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int CHAL_W    = (SIG_BITS > 1) ? $clog2(SIG_BITS) : 1;
   localparam int BIT_W     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [1:0] CMP_DONE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GAP     = 3'd1,
      S_MEASURE = 3'd2,
      S_WRITE   = 3'd3,
      S_DONE    = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   state_t            state_q;
   logic              roen_q, shift_q, wren_q, busy_q, done_q, armed_q;
   logic [ADDR_W-1:0] addr_q, word_q;
   logic [CHAL_W-1:0] chal_q;
   logic [BIT_W-1:0]  bit_q;
   logic [GAP_W-1:0]  gap_q;
   logic              cmp_done;

   assign cmp_done = (bus.counter_ctrl_state == CMP_DONE);

`ifdef PUF_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic            error_q;
   logic [TO_W-1:0] wdog_q;
   assign bus.error = error_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign bus.error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         roen_q  <= 1'b0;
         shift_q <= 1'b0;
         wren_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         armed_q <= 1'b0;
         addr_q  <= '0;
         word_q  <= '0;
         chal_q  <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
`ifdef PUF_TIMEOUT_EN
         error_q <= 1'b0;
         wdog_q  <= '0;
`endif
      end else begin
         shift_q <= 1'b0;
         wren_q  <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  state_q <= S_GAP;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  armed_q <= 1'b0;
                  word_q  <= '0;
                  chal_q  <= '0;
                  bit_q   <= '0;
                  gap_q   <= '0;
`ifdef PUF_TIMEOUT_EN
                  error_q <= 1'b0;
`endif
               end
            end
            S_GAP: begin
               armed_q <= 1'b0;
               if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                  gap_q   <= '0;
                  roen_q  <= 1'b1;
                  state_q <= S_MEASURE;
`ifdef PUF_TIMEOUT_EN
                  wdog_q  <= '0;
`endif
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            S_MEASURE: begin
               // A 2'b11 only counts once a non-complete state has been seen for this bit.
               if (!cmp_done) armed_q <= 1'b1;
               if (armed_q && cmp_done) begin
                  shift_q <= 1'b1;
                  roen_q  <= 1'b0;
                  if (bit_q == BIT_W'(WORD_BITS - 1)) begin
                     bit_q   <= '0;
                     state_q <= S_WRITE;
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     chal_q  <= chal_q + 1'b1;
                     state_q <= S_GAP;
                  end
               end
`ifdef PUF_TIMEOUT_EN
               else if (wdog_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  roen_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
                  state_q <= S_ERROR;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
`endif
            end
            S_WRITE: begin
               // Runs during the shift pulse, so the strobe lands once the word is complete.
               wren_q <= 1'b1;
               addr_q <= word_q;
               if (word_q == ADDR_W'(NUM_WORDS - 1)) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  word_q  <= word_q + 1'b1;
                  chal_q  <= chal_q + 1'b1;
                  state_q <= S_GAP;
               end
            end
            default: begin
               state_q <= S_IDLE;
               roen_q  <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               armed_q <= 1'b0;
               addr_q  <= '0;
               word_q  <= '0;
               chal_q  <= '0;
               bit_q   <= '0;
               gap_q   <= '0;
`ifdef PUF_TIMEOUT_EN
               error_q <= 1'b0;
               wdog_q  <= '0;
`endif
            end
         endcase
      end
   end

   assign bus.roen         = roen_q;
   assign bus.shift_reg_en = shift_q;
   assign bus.ram_wren     = wren_q;
   assign bus.ram_addr     = addr_q;
   assign bus.chal_idx     = chal_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
endmodule

// File: tb/tb_ro_puf_seq_ctrl.sv
// Directed bench for ro_puf_seq_ctrl with SIG_BITS=8, WORD_BITS=4, GAP_CYCLES=2, TIMEOUT_CYCLES=16.
module tb_ro_puf_seq_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   hi, sh, wr;

   always #5 clk = ~clk;

   ro_puf_seq_ctrl_if #(.ADDR_W(1), .CHAL_W(3)) bus ();

   ro_puf_seq_ctrl #(
      .SIG_BITS(8), .WORD_BITS(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // {rst, start, ccs} applied for one edge; exp = {roen, shift, wren, chal[2:0], busy, done, error}
   typedef struct packed {
      logic       rst;
      logic       start;
      logic [1:0] ccs;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input logic r, input logic s, input logic [1:0] c,
                               input logic roen, input logic shf, input logic wren,
                               input logic [2:0] chal, input logic busy, input logic done);
      vec_t v;
      v.rst   = r;
      v.start = s;
      v.ccs   = c;
      v.exp   = {roen, shf, wren, chal, busy, done, 1'b0};
      return v;
   endfunction

   function automatic logic [8:0] outs();
      return {bus.roen, bus.shift_reg_en, bus.ram_wren, bus.chal_idx, bus.busy, bus.done, bus.error};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives a run with a reactive counter-controller model and scores the outputs.
   task automatic run_seq(input string tag, input int poke_at, input int abort_chal);
      int   shifts = 0, rises = 0, lowlen = 0, since = 0, ovl = 0;
      logic prev_roen = 1'b0;
      bit   fin = 0;
      int   chals[$], wr_addr[$], wr_sh[$], lows[$];
      @(negedge clk);
      bus.start = 1'b1;
      bus.counter_ctrl_state = 2'b00;
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, " start busy"}, int'(bus.busy), 1);
      chk({tag, " start done"}, int'(bus.done), 0);
      chk({tag, " start error"}, int'(bus.error), 0);
      chk({tag, " start chal"}, int'(bus.chal_idx), 0);
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         if (bus.shift_reg_en && bus.ram_wren) ovl++;
         if (bus.shift_reg_en) shifts++;
         if (bus.ram_wren) begin
            wr_addr.push_back(int'(bus.ram_addr));
            wr_sh.push_back(shifts);
         end
         if (bus.roen && !prev_roen) begin
            if (rises > 0) lows.push_back(lowlen);
            chals.push_back(int'(bus.chal_idx));
            rises++;
            lowlen = 0;
            since = 0;
            bus.counter_ctrl_state = 2'b00;
         end else if (bus.roen) begin
            since++;
            if (since >= 3) bus.counter_ctrl_state = 2'b11;
         end else if (rises > 0) begin
            lowlen++;
         end
         if (bus.done) fin = 1;
         prev_roen = bus.roen;
         if (abort_chal >= 0 && bus.roen && int'(bus.chal_idx) == abort_chal && since == 1) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk({tag, " abort outs"}, int'({outs(), bus.ram_addr}), 0);
            chk({tag, " abort writes before"}, wr_addr.size(), 1);
            hi = 0;
            for (int k = 0; k < 12; k++) begin
               bus.counter_ctrl_state = (k % 2 == 0) ? 2'b00 : 2'b11;
               @(negedge clk);
               if (bus.shift_reg_en || bus.ram_wren || bus.busy || bus.roen) hi++;
            end
            chk({tag, " quiet after abort"}, hi, 0);
            return;
         end
         bus.start = (cyc == poke_at) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk({tag, " finished in budget"}, int'(fin), 1);
      chk({tag, " shifts"}, shifts, 8);
      chk({tag, " writes"}, wr_addr.size(), 2);
      for (int i = 0; i < wr_addr.size() && i < 2; i++) begin
         chk($sformatf("%s wr%0d addr", tag, i), wr_addr[i], i);
         chk($sformatf("%s wr%0d after shift", tag, i), wr_sh[i], 4 * (i + 1));
      end
      chk({tag, " bits measured"}, chals.size(), 8);
      for (int i = 0; i < chals.size() && i < 8; i++)
         chk($sformatf("%s chal bit%0d", tag, i), chals[i], i);
      for (int j = 0; j < lows.size() && j < 7; j++)
         chk($sformatf("%s roen low before bit%0d", tag, j + 1), lows[j], (j + 1 == 4) ? 3 : 2);
      chk({tag, " overlap"}, ovl, 0);
      chk({tag, " end done"}, int'(bus.done), 1);
      chk({tag, " end busy"}, int'(bus.busy), 0);
      chk({tag, " end roen"}, int'(bus.roen), 0);
      chk({tag, " end chal"}, int'(bus.chal_idx), 7);
      chk({tag, " end error"}, int'(bus.error), 0);
   endtask

   initial begin
      vecs[0]  = mk(1'b1, 1'b1, 2'b11, 0, 0, 0, 3'd0, 0, 0);
      vecs[1]  = mk(1'b1, 1'b0, 2'b00, 0, 0, 0, 3'd0, 0, 0);
      vecs[2]  = mk(1'b0, 1'b0, 2'b00, 0, 0, 0, 3'd0, 0, 0);
      vecs[3]  = mk(1'b0, 1'b1, 2'b11, 0, 0, 0, 3'd0, 1, 0);
      vecs[4]  = mk(1'b0, 1'b0, 2'b11, 0, 0, 0, 3'd0, 1, 0);
      vecs[5]  = mk(1'b0, 1'b0, 2'b11, 1, 0, 0, 3'd0, 1, 0);
      vecs[6]  = mk(1'b0, 1'b0, 2'b11, 1, 0, 0, 3'd0, 1, 0);
      vecs[7]  = mk(1'b0, 1'b0, 2'b11, 1, 0, 0, 3'd0, 1, 0);
      vecs[8]  = mk(1'b0, 1'b0, 2'b00, 1, 0, 0, 3'd0, 1, 0);
      vecs[9]  = mk(1'b0, 1'b0, 2'b11, 0, 1, 0, 3'd1, 1, 0);
      vecs[10] = mk(1'b0, 1'b0, 2'b11, 0, 0, 0, 3'd1, 1, 0);
      vecs[11] = mk(1'b0, 1'b0, 2'b11, 1, 0, 0, 3'd1, 1, 0);
      vecs[12] = mk(1'b0, 1'b0, 2'b11, 1, 0, 0, 3'd1, 1, 0);
      vecs[13] = mk(1'b0, 1'b1, 2'b00, 1, 0, 0, 3'd1, 1, 0);
      vecs[14] = mk(1'b0, 1'b0, 2'b11, 0, 1, 0, 3'd2, 1, 0);
      vecs[15] = mk(1'b1, 1'b0, 2'b11, 0, 0, 0, 3'd0, 0, 0);
      vecs[16] = mk(1'b0, 1'b0, 2'b00, 0, 0, 0, 3'd0, 0, 0);

      rst = 1'b1;
      bus.start = 1'b0;
      bus.counter_ctrl_state = 2'b00;
      repeat (3) @(negedge clk);
      chk("reset outs", int'({outs(), bus.ram_addr}), 0);

      // Reset, stale-done guard, start while busy and reset from GAP, cycle by cycle.
      for (int i = 0; i < 17; i++) begin
         rst = vecs[i].rst;
         bus.start = vecs[i].start;
         bus.counter_ctrl_state = vecs[i].ccs;
         @(negedge clk);
         chk($sformatf("vec%0d outs", i), int'(outs()), int'(vecs[i].exp));
      end
      rst = 1'b0;
      bus.start = 1'b0;

      run_seq("run_poke", 20, -1);
      run_seq("run_from_done", -1, -1);
      run_seq("run_abort", -1, 5);
      run_seq("run_after_abort", -1, -1);

`ifdef PUF_TIMEOUT_EN
      @(negedge clk);
      bus.start = 1'b1;
      bus.counter_ctrl_state = 2'b00;
      @(negedge clk);
      bus.start = 1'b0;
      hi = 0;
      sh = 0;
      wr = 0;
      for (int c = 0; c < 200; c++) begin
         if (bus.roen) hi++;
         if (bus.shift_reg_en) sh++;
         if (bus.ram_wren) wr++;
         if (bus.error) break;
         @(negedge clk);
      end
      chk("timeout error", int'(bus.error), 1);
      chk("timeout measure cycles", hi, 16);
      chk("timeout roen", int'(bus.roen), 0);
      chk("timeout busy", int'(bus.busy), 0);
      chk("timeout shifts", sh, 0);
      chk("timeout writes", wr, 0);
      run_seq("run_after_error", -1, -1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
